branch_predictor_btb: RTL and testbench

Parametrised branch prediction unit: a direct-mapped branch target buffer with per-entry saturating counters and optional gshare indexing. It sits beside the 5-stage pipeline. It predicts the next PC from PCF in Fetch, carries each prediction through its own D and E shadow registers, and resolves it in Execute. On a wrong prediction it raises the redirect/flush and trains the table. It also keeps branch and mispredict performance counters.

---
 rtl/bpu_pkg.sv | 28 ++
 rtl/sat_counter.sv | 19 +
 rtl/branch_predictor_btb.sv | 154 +++++++++++++++
 tb/tb_branch_predictor_btb.sv | 178 +++++++++++++++++
 4 files changed

// File: rtl/bpu_pkg.sv
// rtl/bpu_pkg.sv - shared types and constants for the branch prediction unit
package bpu_pkg;

  localparam int BPU_WIDTH    = 32;
  localparam int BPU_ENTRIES  = 16;
  localparam int BPU_CTR_BITS = 2;
  localparam int BPU_IDX      = $clog2(BPU_ENTRIES);
  localparam int BPU_TAG_BITS = BPU_WIDTH - BPU_IDX - 2;

  localparam logic [BPU_CTR_BITS-1:0] CTR_WEAK_T  = BPU_CTR_BITS'(1) << (BPU_CTR_BITS - 1);
  localparam logic [BPU_CTR_BITS-1:0] CTR_WEAK_NT = CTR_WEAK_T - BPU_CTR_BITS'(1);

  typedef struct packed {
    logic                    valid;
    logic [BPU_TAG_BITS-1:0] tag;
    logic [BPU_WIDTH-1:0]    target;
    logic [BPU_CTR_BITS-1:0] ctr;
    logic                    is_jump;
  } btb_entry_t;

  typedef struct packed {
    logic                 valid;
    logic                 taken;
    logic [BPU_WIDTH-1:0] target;
    logic [BPU_IDX-1:0]   index;
  } pred_meta_t;

endpackage

// File: rtl/sat_counter.sv
// rtl/sat_counter.sv - up/down saturating counter next-value logic
module sat_counter #(
  parameter int CTR_BITS = 2
) (
  input  logic [CTR_BITS-1:0] ctr_i,
  input  logic                up_i,
  output logic [CTR_BITS-1:0] ctr_o
);

  always_comb begin
    ctr_o = ctr_i;
    if (up_i) begin
      if (ctr_i != '1) ctr_o = ctr_i + CTR_BITS'(1);
    end else begin
      if (ctr_i != '0) ctr_o = ctr_i - CTR_BITS'(1);
    end
  end

endmodule

// File: rtl/branch_predictor_btb.sv
// rtl/branch_predictor_btb.sv - direct-mapped BTB with saturating counters and optional gshare index
module branch_predictor_btb
  import bpu_pkg::*;
#(
  parameter int WIDTH    = BPU_WIDTH,
  parameter int ENTRIES  = BPU_ENTRIES,
  parameter int CTR_BITS = BPU_CTR_BITS,
  parameter int GHR_BITS = 0
) (
  input  logic             clk,
  input  logic             rst,
  input  logic [WIDTH-1:0] PCF,
  input  logic             stall,
  input  logic             flush,
  input  logic             BranchE,
  input  logic             JumpE,
  input  logic             TakenE,
  input  logic [WIDTH-1:0] PCE,
  input  logic [WIDTH-1:0] PCPlus4E,
  input  logic [WIDTH-1:0] TargetE,
  output logic [WIDTH-1:0] PCPredF,
  output logic             PredTakenF,
  output logic             MispredictE,
  output logic [WIDTH-1:0] RedirectPCE,
  output logic [31:0]      BranchCount,
  output logic [31:0]      MispredCount
);

  localparam int IDX      = $clog2(ENTRIES);
  localparam int TAG_BITS = WIDTH - IDX - 2;

  logic                valid_q  [ENTRIES];
  logic [CTR_BITS-1:0] ctr_q    [ENTRIES];
  logic [TAG_BITS-1:0] tag_q    [ENTRIES];
  logic [WIDTH-1:0]    target_q [ENTRIES];
  logic                jump_q   [ENTRIES];

  pred_meta_t d_q, d_d, e_q, e_d, f_meta;
  btb_entry_t f_entry;
  logic [IDX-1:0] f_idx, e_idx, ghr_ext;
  logic f_hit, e_hit, resolve, actual;
  logic [CTR_BITS-1:0] upd_ctr;
  logic [31:0] branch_cnt_q, mispred_cnt_q;
  logic unused_pce;

  assign unused_pce = ^PCE[IDX+1:0];

  assign resolve = e_q.valid && (BranchE || JumpE);
  assign actual  = JumpE || TakenE;

  // History only advances on resolved conditional branches, never speculatively
  generate
    if (GHR_BITS > 0) begin : g_ghr
      logic [GHR_BITS-1:0] ghr_q;
      always_ff @(posedge clk or negedge rst) begin
        if (!rst) ghr_q <= '0;
        else if (resolve && BranchE && !JumpE) ghr_q <= (ghr_q << 1) | GHR_BITS'(actual);
      end
      assign ghr_ext = IDX'(ghr_q);
    end else begin : g_no_ghr
      assign ghr_ext = '0;
    end
  endgenerate

  assign f_idx = PCF[IDX+1:2] ^ ghr_ext;

  always_comb begin
    f_entry.valid   = valid_q[f_idx];
    f_entry.tag     = tag_q[f_idx];
    f_entry.target  = target_q[f_idx];
    f_entry.ctr     = ctr_q[f_idx];
    f_entry.is_jump = jump_q[f_idx];
    f_hit      = f_entry.valid && (f_entry.tag == PCF[WIDTH-1:IDX+2]);
    PredTakenF = f_hit && (f_entry.is_jump || f_entry.ctr[CTR_BITS-1]);
    PCPredF    = PredTakenF ? f_entry.target : PCF + WIDTH'(4);
    f_meta     = '{valid: 1'b1, taken: PredTakenF, target: f_entry.target, index: f_idx};
  end

  always_comb begin
    d_d = stall ? d_q : f_meta;
    e_d = d_q;
    if (stall) e_d.valid = 1'b0;
    if (flush || MispredictE) begin
      d_d.valid = 1'b0;
      e_d.valid = 1'b0;
    end
  end

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      d_q <= '0;
      e_q <= '0;
    end else begin
      d_q <= d_d;
      e_q <= e_d;
    end
  end

  always_comb begin
    MispredictE = resolve && ((actual != e_q.taken) || (actual && (TargetE != e_q.target)));
    RedirectPCE = '0;
    if (MispredictE) RedirectPCE = actual ? TargetE : PCPlus4E;
  end

  assign e_idx = e_q.index;
  assign e_hit = valid_q[e_idx] && (tag_q[e_idx] == PCE[WIDTH-1:IDX+2]);

  sat_counter #(.CTR_BITS(CTR_BITS)) u_sat_counter (
    .ctr_i (ctr_q[e_idx]),
    .up_i  (actual),
    .ctr_o (upd_ctr)
  );

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      for (int i = 0; i < ENTRIES; i++) begin
        valid_q[i] <= 1'b0;
        ctr_q[i]   <= CTR_WEAK_NT;
      end
    end else if (resolve) begin
      if (e_hit) begin
        ctr_q[e_idx] <= upd_ctr;
      end else if (actual) begin
        valid_q[e_idx] <= 1'b1;
        ctr_q[e_idx]   <= CTR_WEAK_T;
      end
    end
  end

  // Tags and targets carry no reset; gating on rst keeps a reset edge from training them
  always_ff @(posedge clk) begin
    if (rst && resolve && actual) begin
      target_q[e_idx] <= TargetE;
      if (!e_hit) begin
        tag_q[e_idx]  <= PCE[WIDTH-1:IDX+2];
        jump_q[e_idx] <= JumpE;
      end
    end
  end

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      branch_cnt_q  <= '0;
      mispred_cnt_q <= '0;
    end else begin
      if (resolve && branch_cnt_q != '1) branch_cnt_q <= branch_cnt_q + 32'd1;
      if (MispredictE && mispred_cnt_q != '1) mispred_cnt_q <= mispred_cnt_q + 32'd1;
    end
  end

  assign BranchCount  = branch_cnt_q;
  assign MispredCount = mispred_cnt_q;

endmodule

// File: tb/tb_branch_predictor_btb.sv
// tb/tb_branch_predictor_btb.sv - directed table-driven bench for branch_predictor_btb
module tb_branch_predictor_btb;

  logic        clk = 1'b0;
  logic        rst;
  logic [31:0] PCF;
  logic        stall, flush, BranchE, JumpE, TakenE;
  logic [31:0] PCE, PCPlus4E, TargetE;
  logic [31:0] PCPredF;
  logic        PredTakenF, MispredictE;
  logic [31:0] RedirectPCE, BranchCount, MispredCount;

  int checks = 0;
  int errors = 0;

  typedef struct {
    logic [31:0] pc;
    logic        br;
    logic        jmp;
    logic        tk;
    logic [31:0] tgt;
    logic        exp_mis;
    logic [31:0] exp_redir;
    logic        exp_pt;
    logic [31:0] exp_pcpred;
  } vec_t;

  vec_t vecs[13];

  branch_predictor_btb dut (
    .clk(clk), .rst(rst), .PCF(PCF), .stall(stall), .flush(flush),
    .BranchE(BranchE), .JumpE(JumpE), .TakenE(TakenE), .PCE(PCE),
    .PCPlus4E(PCPlus4E), .TargetE(TargetE), .PCPredF(PCPredF),
    .PredTakenF(PredTakenF), .MispredictE(MispredictE), .RedirectPCE(RedirectPCE),
    .BranchCount(BranchCount), .MispredCount(MispredCount)
  );

  always #5 clk = ~clk;

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got %h expected %h", name, act, exp);
    end
  endtask

  task automatic step();
    @(posedge clk);
    #2;
  endtask

  task automatic clear_e();
    BranchE = 1'b0; JumpE = 1'b0; TakenE = 1'b0;
  endtask

  task automatic resolve_in(input logic [31:0] pc, input logic br, input logic jmp,
                            input logic tk, input logic [31:0] tgt);
    PCE = pc; PCPlus4E = pc + 32'd4; BranchE = br; JumpE = jmp; TakenE = tk; TargetE = tgt;
  endtask

  // Walk a PC through F and D so its prediction sits in the E shadow
  task automatic issue(input logic [31:0] pc);
    PCF = pc;
    step();
    PCF = 32'h900;
    step();
  endtask

  initial begin
    vecs[0]  = '{32'h100, 1'b1, 1'b0, 1'b1, 32'h080, 1'b1, 32'h080, 1'b1, 32'h080};
    vecs[1]  = '{32'h100, 1'b1, 1'b0, 1'b0, 32'h080, 1'b1, 32'h104, 1'b0, 32'h104};
    vecs[2]  = '{32'h100, 1'b1, 1'b0, 1'b0, 32'h080, 1'b0, 32'h000, 1'b0, 32'h104};
    vecs[3]  = '{32'h100, 1'b1, 1'b0, 1'b0, 32'h080, 1'b0, 32'h000, 1'b0, 32'h104};
    vecs[4]  = '{32'h100, 1'b1, 1'b0, 1'b1, 32'h080, 1'b1, 32'h080, 1'b0, 32'h104};
    vecs[5]  = '{32'h200, 1'b0, 1'b1, 1'b0, 32'h040, 1'b1, 32'h040, 1'b1, 32'h040};
    vecs[6]  = '{32'h200, 1'b0, 1'b1, 1'b0, 32'h040, 1'b0, 32'h000, 1'b1, 32'h040};
    vecs[7]  = '{32'h100, 1'b1, 1'b0, 1'b0, 32'h080, 1'b0, 32'h000, 1'b0, 32'h104};
    vecs[8]  = '{32'h204, 1'b1, 1'b0, 1'b1, 32'h300, 1'b1, 32'h300, 1'b1, 32'h300};
    vecs[9]  = '{32'h204, 1'b1, 1'b0, 1'b1, 32'h310, 1'b1, 32'h310, 1'b1, 32'h310};
    vecs[10] = '{32'h200, 1'b1, 1'b0, 1'b0, 32'h040, 1'b1, 32'h204, 1'b1, 32'h040};
    vecs[11] = '{32'h200, 1'b1, 1'b0, 1'b0, 32'h040, 1'b1, 32'h204, 1'b1, 32'h040};
    vecs[12] = '{32'h300, 1'b0, 1'b0, 1'b0, 32'h000, 1'b0, 32'h000, 1'b0, 32'h304};

    rst = 1'b0; PCF = 32'h100; stall = 1'b0; flush = 1'b0;
    PCE = '0; PCPlus4E = '0; TargetE = '0;
    clear_e();
    step();
    step();
    rst = 1'b1;
    #1;
    chk("reset_pred_taken", {31'd0, PredTakenF}, 32'd0);
    chk("reset_pcpred", PCPredF, 32'h104);
    chk("reset_branch_cnt", BranchCount, 32'd0);
    chk("reset_mispred_cnt", MispredCount, 32'd0);
    chk("reset_mispredict", {31'd0, MispredictE}, 32'd0);
    chk("reset_redirect", RedirectPCE, 32'd0);

    for (int i = 0; i < 13; i++) begin
      issue(vecs[i].pc);
      resolve_in(vecs[i].pc, vecs[i].br, vecs[i].jmp, vecs[i].tk, vecs[i].tgt);
      #1;
      chk($sformatf("v%0d_mispredict", i), {31'd0, MispredictE}, {31'd0, vecs[i].exp_mis});
      chk($sformatf("v%0d_redirect", i), RedirectPCE, vecs[i].exp_redir);
      step();
      clear_e();
      PCF = vecs[i].pc;
      #1;
      chk($sformatf("v%0d_pred_taken", i), {31'd0, PredTakenF}, {31'd0, vecs[i].exp_pt});
      chk($sformatf("v%0d_pcpred", i), PCPredF, vecs[i].exp_pcpred);
    end
    chk("table_branch_cnt", BranchCount, 32'd12);
    chk("table_mispred_cnt", MispredCount, 32'd8);

    // Stall with a predicted-taken branch in D: E must see bubbles only
    PCF = 32'h204;
    step();
    stall = 1'b1; PCF = 32'h900;
    step();
    resolve_in(32'h204, 1'b1, 1'b0, 1'b1, 32'h310);
    #1;
    chk("stall1_mispredict", {31'd0, MispredictE}, 32'd0);
    step();
    chk("stall2_mispredict", {31'd0, MispredictE}, 32'd0);
    chk("stall2_branch_cnt", BranchCount, 32'd12);
    stall = 1'b0;
    step();
    chk("stall_release_mispredict", {31'd0, MispredictE}, 32'd0);
    step();
    clear_e();
    #1;
    chk("stall_branch_cnt", BranchCount, 32'd13);
    chk("stall_mispred_cnt", MispredCount, 32'd8);

    // Flush wins over a same-cycle stall
    PCF = 32'h204;
    step();
    flush = 1'b1; stall = 1'b1;
    step();
    flush = 1'b0; stall = 1'b0; PCF = 32'h900;
    resolve_in(32'h204, 1'b1, 1'b0, 1'b0, 32'h310);
    #1;
    chk("flush_e_invalid", {31'd0, MispredictE}, 32'd0);
    step();
    chk("flush_d_invalid", {31'd0, MispredictE}, 32'd0);
    step();
    clear_e();
    #1;
    chk("flush_branch_cnt", BranchCount, 32'd13);

    // Reset while a mispredict is pending in E
    issue(32'h204);
    resolve_in(32'h204, 1'b1, 1'b0, 1'b0, 32'h310);
    #1;
    chk("pre_reset_mispredict", {31'd0, MispredictE}, 32'd1);
    rst = 1'b0;
    #1;
    chk("async_reset_mispredict", {31'd0, MispredictE}, 32'd0);
    chk("async_reset_redirect", RedirectPCE, 32'd0);
    chk("async_reset_branch_cnt", BranchCount, 32'd0);
    step();
    rst = 1'b1;
    clear_e();
    PCF = 32'h204;
    #1;
    chk("post_reset_pt_204", {31'd0, PredTakenF}, 32'd0);
    chk("post_reset_pcpred_204", PCPredF, 32'h208);
    PCF = 32'h200;
    #1;
    chk("post_reset_pt_200", {31'd0, PredTakenF}, 32'd0);
    chk("post_reset_pcpred_200", PCPredF, 32'h204);
    chk("post_reset_mispred_cnt", MispredCount, 32'd0);

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
